// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types, constants and count clamp for the boot loader
package boot_pkg;

  localparam int BOOT_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHK,
    DONE
  } boot_state_t;

  // Limit the requested word count to the number of addressable cache words.
  function automatic logic [31:0] clamp_count(input logic [31:0] count, input int addr_w);
    logic [31:0] limit;
    limit = 32'd1 << addr_w;
    return (count > limit) ? limit : count;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - byte-stream input and instruction-cache write port of the boot loader
interface boot_loader_if
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
);

  logic                   rx_valid;
  logic [BOOT_BYTE_W-1:0] rx_data;
  logic                   rx_ready;
  logic                   boot_up;
  logic [ADDR_W-1:0]      boot_addr;
  logic [WORD_W-1:0]      boot_datai;
  logic                   boot_web;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, boot_up, boot_addr, boot_datai, boot_web
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, boot_up, boot_addr, boot_datai, boot_web
  );

endinterface

// File: rtl/boot_word_assembler.sv
// rtl/boot_word_assembler.sv - packs bytes MSB-first into instruction words
module boot_word_assembler
  import boot_pkg::*;
#(
  parameter int WORD_W = 32
)
(
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [BOOT_BYTE_W-1:0] data,
  output logic                   word_valid,
  output logic [WORD_W-1:0]      word
);

  localparam int BYTES_PER_WORD = WORD_W / BOOT_BYTE_W;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [CNT_W-1:0]              cnt_q;
  logic [WORD_W-BOOT_BYTE_W-1:0] shift_q;
  logic                          last_byte;

  assign last_byte  = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
  // The completed word is presented combinationally on the final byte's handshake.
  assign word       = {shift_q, data};
  assign word_valid = accept && last_byte;

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (accept) begin
      shift_q <= word[WORD_W-BOOT_BYTE_W-1:0];
      cnt_q   <= last_byte ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streams bytes into the instruction cache; BOOT_CHECKSUM_EN adds a trailing XOR check byte
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  boot_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = ADDR_W + 1;

  boot_state_t       state_q, state_d;
  logic [CNT_W-1:0]  count_q, wr_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              start_ok, accept, word_accept, last_word;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign start_ok    = start && (state_q == IDLE);
  assign accept      = bus.rx_valid && bus.rx_ready;
  assign word_accept = accept && (state_q == RECV);
  assign last_word   = ((wr_cnt_q + CNT_W'(1)) == count_q);

  boot_word_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk        (clk),
    .clear      (rst || start_ok),
    .accept     (word_accept),
    .data       (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (word_count == '0) ? DONE : RECV;
      RECV:  if (word_valid) state_d = WRITE;
      WRITE: begin
        if (!last_word) begin
          state_d = RECV;
        end else begin
`ifdef BOOT_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end
      end
      CHK:   if (accept) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_ready   = (state_q == RECV) || (state_q == CHK);
  assign bus.boot_up    = (state_q == RECV) || (state_q == WRITE) || (state_q == CHK);
  assign bus.boot_web   = (state_q != WRITE);
  assign bus.boot_addr  = addr_q;
  assign bus.boot_datai = data_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_cnt_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        count_q  <= CNT_W'(clamp_count(32'(word_count), ADDR_W));
        wr_cnt_q <= '0;
        if (word_count != '0) addr_q <= '0;
      end
      if (word_valid) data_q <= word;
      // The address only advances when another word follows, so DONE shows the last one written.
      if (state_q == WRITE) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
        if (!last_word) addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  logic [BOOT_BYTE_W-1:0] csum_q;
  logic                   err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        csum_q <= '0;
        err_q  <= 1'b0;
      end else if (word_accept) begin
        csum_q <= csum_q ^ bus.rx_data;
      end
      if ((state_q == CHK) && accept) err_q <= err_q || (bus.rx_data != csum_q);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
